// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the SPI slave.
package spi_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int SCLK_HALF_MIN = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous pin plus rise/fall detection.
// Level lags the pin by STAGES clk; edges are one-cycle pulses aligned with level.
module spi_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  // Reset to 0 so a cs already held low through reset never looks like a new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~dly_q;
  assign fall  = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// Mode-0 SPI slave: MOSI bytes to rx_data/rx_valid, holding-register byte out on MISO (SPI_SLAVE_ECHO_EN: resend last rx byte when empty).
// Pins see SYNC_STAGES+1 clk of latency; tx_load is refused while tx_ready is low.
module spi_slave_rx_tx
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);

  localparam int              CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_s_unused, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;
  logic cs_s_unused;

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (cs),
    .level (cs_s),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (sclk),
    .level (sclk_s_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_mosi_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (mosi),
    .level (mosi_s),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  assign cs_s_unused = cs_s;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic              byte_done;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] empty_fill;
  logic [DATA_W-1:0] tx_next;
  logic [DATA_W-1:0] rx_shifted;
  logic              hold_take;

`ifdef SPI_SLAVE_ECHO_EN
  assign empty_fill = rx_data;
`else
  assign empty_fill = '0;
`endif

  assign hold_take  = (state == LOAD) && !cs_rise && !tx_ready;
  assign tx_next    = tx_ready ? empty_fill : hold_q;
  assign rx_shifted = {rx_sr[DATA_W-2:0], mosi_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      hold_q    <= '0;
      tx_ready  <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      miso      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;

      // A load arriving while LOAD drains the register refills it straight away.
      if (tx_load && (tx_ready || hold_take)) begin
        hold_q   <= tx_data;
        tx_ready <= 1'b0;
      end else if (hold_take) begin
        tx_ready <= 1'b1;
      end

      if (cs_rise) begin
        state     <= IDLE;
        miso      <= 1'b0;
        busy      <= 1'b0;
        bit_cnt   <= '0;
        byte_done <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            miso <= 1'b0;
            busy <= 1'b0;
            if (cs_fall) state <= LOAD;
          end
          LOAD: begin
            tx_sr     <= tx_next;
            miso      <= tx_next[DATA_W-1];
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
          SHIFT: begin
            if (sclk_rise) begin
              rx_sr <= rx_shifted;
              if (bit_cnt == LAST) begin
                rx_data   <= rx_shifted;
                rx_valid  <= 1'b1;
                bit_cnt   <= '0;
                byte_done <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (sclk_fall) begin
              // The falling edge after a full byte reloads instead of shifting.
              if (byte_done) begin
                byte_done <= 1'b0;
                state     <= LOAD;
              end else begin
                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                miso  <= tx_sr[DATA_W-2];
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Directed bench for spi_slave_rx_tx: table of single-byte frames plus hand sequences.
module tb_spi_slave_rx_tx;
  import spi_pkg::*;

  localparam int HALF = SCLK_HALF_MIN + 1;
`ifdef SPI_SLAVE_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, cs, sclk, mosi, miso;
  logic [7:0] tx_data, rx_data;
  logic       tx_load, tx_ready, rx_valid, busy;

  int tests  = 0;
  int failed = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  spi_slave_rx_tx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy)
  );

  always @(negedge clk) if (!rst && rx_valid) rx_q.push_back(rx_data);

  typedef struct {
    logic       ld;
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_miso;
    logic [7:0] exp_miso_echo;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[6];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  // Master side: mosi changes with sclk low, miso is sampled just before each rise.
  task automatic xfer_byte(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int b = 0; b < nbits; b++) begin
      mosi = mo[7-b];
      tick(HALF);
      mi[7-b] = miso;
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_start();
    cs = 1'b0;
    tick(8);
  endtask

  task automatic cs_end();
    tick(HALF);
    cs = 1'b1;
    tick(8);
  endtask

  function automatic logic [7:0] q_at(input int i);
    return (rx_q.size() > i) ? rx_q[i] : 8'hxx;
  endfunction

  initial begin
    logic [7:0] mi, mi2, exp_tail;

    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_load = 1'b0; tx_data = 8'h00;

    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'hA5, 8'h3C};
    vecs[1] = '{1'b0, 8'h00, 8'h96, 8'h00, 8'h3C, 8'h96};
    vecs[2] = '{1'b0, 8'h00, 8'h5A, 8'h00, 8'h96, 8'h5A};
    vecs[3] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00};
    vecs[4] = '{1'b1, 8'h00, 8'h81, 8'h00, 8'h00, 8'h81};
    vecs[5] = '{1'b1, 8'h6B, 8'hE7, 8'h6B, 8'h6B, 8'hE7};

    tick(2);
    rst = 1'b0;
    tick(1);
    check("reset_miso", miso, 0);
    check("reset_tx_ready", tx_ready, 1);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_busy", busy, 0);
    tick(4);

    for (int i = 0; i < 6; i++) begin
      rx_q.delete();
      if (vecs[i].ld) begin
        do_load(vecs[i].tx);
        check("vec_tx_ready_loaded", tx_ready, 0);
      end
      cs_start();
      check("vec_busy_in_frame", busy, 1);
      check("vec_tx_ready_after_load", tx_ready, 1);
      xfer_byte(vecs[i].mo, 8, mi);
      cs_end();
      check("vec_miso_byte", mi, ECHO ? vecs[i].exp_miso_echo : vecs[i].exp_miso);
      check("vec_rx_count", rx_q.size(), 1);
      check("vec_rx_data", q_at(0), vecs[i].exp_rx);
      check("vec_busy_idle", busy, 0);
      check("vec_miso_idle", miso, 0);
    end

    // Back-to-back bytes within one cs assertion; reload while byte 1 is in flight.
    rx_q.delete();
    do_load(8'hC7);
    cs_start();
    do_load(8'h55);
    check("b2b_tx_ready_mid", tx_ready, 0);
    xfer_byte(8'h01, 8, mi);
    tick(HALF);
    xfer_byte(8'hFF, 8, mi2);
    check("b2b_busy", busy, 1);
    cs_end();
    check("b2b_miso_byte1", mi, 8'hC7);
    check("b2b_miso_byte2", mi2, 8'h55);
    check("b2b_rx_count", rx_q.size(), 2);
    check("b2b_rx_byte1", q_at(0), 8'h01);
    check("b2b_rx_byte2", q_at(1), 8'hFF);
    check("b2b_tx_ready_end", tx_ready, 1);

    // Second load while the holding register is full is dropped.
    rx_q.delete();
    do_load(8'h11);
    do_load(8'h22);
    check("hold_tx_ready_full", tx_ready, 0);
    cs_start();
    xfer_byte(8'hD2, 8, mi);
    cs_end();
    check("hold_miso", mi, 8'h11);
    check("hold_tx_ready_after", tx_ready, 1);
    rx_q.delete();
    cs_start();
    xfer_byte(8'h5C, 8, mi);
    cs_end();
    exp_tail = ECHO ? 8'hD2 : 8'h00;
    check("hold_tail_miso", mi, exp_tail);
    check("hold_tail_rx", q_at(0), 8'h5C);

    // Abort after 5 bits: no rx_valid, rx_data kept, counter cleared for next frame.
    rx_q.delete();
    cs_start();
    xfer_byte(8'hC3, 5, mi);
    cs_end();
    check("abort_rx_count", rx_q.size(), 0);
    check("abort_rx_data", rx_data, 8'h5C);
    check("abort_miso", miso, 0);
    check("abort_busy", busy, 0);
    do_load(8'h42);
    cs_start();
    xfer_byte(8'h7E, 8, mi);
    cs_end();
    check("abort_next_rx_count", rx_q.size(), 1);
    check("abort_next_rx", q_at(0), 8'h7E);
    check("abort_next_miso", mi, 8'h42);

    // Reset in the middle of a frame.
    rx_q.delete();
    do_load(8'h9A);
    cs_start();
    xfer_byte(8'hB4, 3, mi);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    check("midrst_busy", busy, 0);
    check("midrst_miso", miso, 0);
    check("midrst_tx_ready", tx_ready, 1);
    check("midrst_rx_data", rx_data, 8'h00);
    cs = 1'b1;
    tick(8);
    cs_start();
    xfer_byte(8'h24, 8, mi);
    cs_end();
    check("midrst_next_miso", mi, 8'h00);
    check("midrst_next_rx", q_at(0), 8'h24);
    check("midrst_next_count", rx_q.size(), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx_tx.md
Name: spi_slave_rx_tx

Overview:
- Single-slave SPI peripheral.
- Sits directly downstream of the SPI master on the cs/sclk/mosi/miso wires.
- Oversamples the SPI pins with the local system clock.
- Deserialises each MOSI byte into a parallel rx word, and serialises a host-loaded tx byte onto MISO in the same frame.
- Mode 0 timing, MSB first, one byte per 8 sclk cycles; multiple bytes per cs assertion are allowed.

Parameters:
- DATA_W, 8: bits per SPI word.
- SYNC_STAGES, 2: flops in each pin synchroniser (cs, sclk, mosi); minimum 2.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- cs  input  1  SPI chip select, active low (asynchronous to clk).
- sclk  input  1  SPI serial clock (asynchronous to clk).
- mosi  input  1  SPI data from master.
- miso  output  1  SPI data to master.
- tx_data  input  DATA_W  byte to transmit in the next frame.
- tx_load  input  1  one-cycle strobe; captures tx_data into the holding register.
- tx_ready  output  1  holding register empty; tx_load is accepted.
- rx_data  output  DATA_W  last complete received byte; stable until the next rx_valid.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- busy  output  1  frame in progress (synchronised cs low).

Behaviour:
- Reset values: miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, FSM=IDLE, bit counter=0, holding register=0, shift registers=0.
- Synchronisation and edge detection:
  - cs, sclk and mosi each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last synchroniser stage against one extra delay flop.
  - Interface constraint: sclk high and low phases must each be ≥3 clk periods. Faster sclk is out of spec and behaviour is undefined.
- FSM states IDLE, LOAD, SHIFT.
  - IDLE: busy=0, miso=0. A synchronised cs falling edge moves to LOAD.
  - LOAD (one cycle):
    - If the holding register is full, tx shift register ← holding, and tx_ready←1.
    - Otherwise, tx shift register ← 0.
    - miso ← tx shift MSB, bit counter ← 0, busy←1. Go to SHIFT.
  - SHIFT:
    - sclk rising edge: rx shift ← {rx shift[DATA_W-2:0], mosi_sync}; counter+1.
    - sclk falling edge: tx shift left by 1; miso ← new MSB.
    - When the counter reaches DATA_W on a rising edge:
      - rx_data ← assembled byte; rx_valid=1 on the next cycle, for exactly one cycle.
      - Counter ← 0, and go back to LOAD on the following falling edge so back-to-back bytes need no cs toggle. The next byte's MSB is driven on that falling edge.
- cs rises (synchronised) in any state:
  - Return to IDLE next cycle and set miso=0.
  - A partial byte (counter 1..DATA_W-1) is discarded with no rx_valid, and the counter clears.
- Holding register:
  - tx_load with tx_ready=1: capture tx_data, tx_ready←0.
  - tx_load with tx_ready=0: ignored; the holding register is unchanged.
  - tx_load in the same cycle as a LOAD that empties the holding register: the load wins, and tx_ready stays 0 with the new data.
- rst asserted mid-frame: all state returns to reset values in the next cycle. The frame in progress is lost until a fresh cs falling edge.

Optional Feature:
- Macro SPI_SLAVE_ECHO_EN.
- When defined: in LOAD with an empty holding register, the tx shift register loads the previous rx_data instead of 0. The slave therefore echoes the last received byte.
- When undefined: an empty holding register sends all zeros.
- Port list is identical in both builds.

Decomposition:
- Package spi_pkg holds:
  - default DATA_W;
  - the FSM state encoding (IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2);
  - the minimum sclk half-period constant (3).
- One sub-module, spi_pin_sync: a SYNC_STAGES synchroniser plus edge detector, outputting level, rise and fall. Instantiate it three times (edge outputs are unused for mosi).

Test Plan:
- Reset: hold rst 2 cycles → miso=0, tx_ready=1, rx_valid=0, rx_data=8'h00, busy=0.
- Single byte: tx_load tx_data=8'hA5; master sends 8'h3C with sclk half-period 4 clk → miso bits 1,0,1,0,0,1,0,1, one rx_valid pulse with rx_data=8'h3C, tx_ready=1 after LOAD.
- Back-to-back: cs held low, master sends 8'h01 then 8'hFF, tx_load 8'h55 during byte 1 → two rx_valid pulses (8'h01, 8'hFF); second MISO byte=8'h55, first=preloaded value.
- Abort: cs rises after 5 sclk cycles of 8'hC3 → no rx_valid, rx_data unchanged, miso=0; the next full frame of 8'h7E yields rx_data=8'h7E.
- Holding full: two tx_load strobes (8'h11 then 8'h22) while tx_ready=0 → 8'h11 transmitted, 8'h22 ignored.
- Echo (SPI_SLAVE_ECHO_EN): frame 1 receives 8'h96 with no tx_load; frame 2 → MISO shifts 8'h96. Without the macro → MISO shifts 8'h00.
